seg_scan_decoder: RTL and testbench

Receive-side counterpart of the BCD-to-segment encoder. The block samples a multiplexed 7-segment bus (segment pattern plus one-hot digit select), waits until the pair is stable, and decodes the pattern back to BCD. It holds one captured value per digit and flags illegal patterns. It sits on the display bus as a self-check monitor and as a readback path for the test bench and status logic.

---
 rtl/seg_scan_decoder.sv | 113 +++++++++++
 tb/tb_seg_scan_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Samples a multiplexed 7-segment bus ({sel, seg}), waits for the pair to be
// stable for STABLE consecutive matching samples and decodes the pattern back
// to BCD, storing one value, decimal point and error flag per digit.
module seg_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            seg,
  input  logic [DIGITS-1:0]     sel,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     err,
  output logic [DIGITS-1:0]     upd
);

  localparam int          IN_W       = DIGITS + 8;
  localparam logic [3:0]  STABLE_C   = 4'(STABLE);
  localparam logic [3:0]  STABLE_M1  = 4'(STABLE - 1);

  // Decode seg[6:0] into {err, bcd}; blank maps to E, anything unknown to F.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h3F:   res = {1'b0, 4'h0};
      7'h06:   res = {1'b0, 4'h1};
      7'h5B:   res = {1'b0, 4'h2};
      7'h4F:   res = {1'b0, 4'h3};
      7'h66:   res = {1'b0, 4'h4};
      7'h6D:   res = {1'b0, 4'h5};
      7'h7D:   res = {1'b0, 4'h6};
      7'h07:   res = {1'b0, 4'h7};
      7'h7F:   res = {1'b0, 4'h8};
      7'h6F:   res = {1'b0, 4'h9};
      7'h00:   res = {1'b0, 4'hE};
      default: res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

  logic [IN_W-1:0]     s1_r;
  logic [3:0]          cnt_r;
  logic [4*DIGITS-1:0] bcd_r;
  logic [DIGITS-1:0]   dp_r;
  logic [DIGITS-1:0]   err_r;
  logic [DIGITS-1:0]   upd_r;

  logic [IN_W-1:0]     in_s;
  logic                onehot_s;
  logic                capture_s;
  logic [3:0]          cnt_nxt_s;
  logic [4:0]          dec_s;

  // Stability qualification: compare the live bus against the last sample
  // and decide the next run count and whether this edge captures.
  always_comb begin
    in_s      = {sel, seg};
    onehot_s  = (sel != {DIGITS{1'b0}}) &&
                ((sel & (sel - {{(DIGITS-1){1'b0}}, 1'b1})) == {DIGITS{1'b0}});
    capture_s = 1'b0;
    cnt_nxt_s = 4'd0;
    dec_s     = decode_seg(seg[6:0]);
    if (onehot_s && (in_s == s1_r)) begin
      capture_s = (cnt_r == STABLE_M1);
      if (cnt_r == STABLE_C) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + 4'd1;
      end
    end else begin
      capture_s = 1'b0;
      cnt_nxt_s = 4'd0;
    end
  end

  // Sample register and saturating stability counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_r  <= {IN_W{1'b0}};
      cnt_r <= 4'd0;
    end else begin
      s1_r  <= in_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  // Per-digit capture storage and the one-cycle update pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bcd_r <= {DIGITS{4'hE}};
      dp_r  <= {DIGITS{1'b0}};
      err_r <= {DIGITS{1'b0}};
      upd_r <= {DIGITS{1'b0}};
    end else begin
      upd_r <= capture_s ? sel : {DIGITS{1'b0}};
      for (int i = 0; i < DIGITS; i++) begin
        if (capture_s && sel[i]) begin
          bcd_r[4*i +: 4] <= dec_s[3:0];
          dp_r[i]         <= seg[7];
          err_r[i]        <= dec_s[4];
        end
      end
    end
  end

  assign bcd = bcd_r;
  assign dp  = dp_r;
  assign err = err_r;
  assign upd = upd_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios followed by
// randomized bus traffic, all checked against a run-length reference model.
module tb_seg_scan_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic                clock;
  logic                reset_n;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   sel;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   err;
  logic [DIGITS-1:0]   upd;

  seg_scan_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .seg     (seg),
    .sel     (sel),
    .bcd     (bcd),
    .dp      (dp),
    .err     (err),
    .upd     (upd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: counts how many consecutive edges the same one-hot bus
  // value has been seen; a capture is the (STABLE+1)-th such edge.
  logic [7:0] patterns [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic [11:0] m_prev;
  bit          m_prev_valid;
  int          m_run;
  logic [3:0]  m_bcd [DIGITS];
  logic        m_dp  [DIGITS];
  logic        m_err [DIGITS];
  logic [DIGITS-1:0] m_upd;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    if (p == 7'h00) return {1'b0, 4'hE};
    for (int k = 0; k < 10; k++)
      if (patterns[k][6:0] == p) return {1'b0, 4'(k)};
    return {1'b1, 4'hF};
  endfunction

  task automatic model_reset();
    m_prev_valid = 0;
    m_prev = '0;
    m_run = 0;
    m_upd = '0;
    for (int d = 0; d < DIGITS; d++) begin
      m_bcd[d] = 4'hE; m_dp[d] = 1'b0; m_err[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [DIGITS-1:0] s, input logic [7:0] g);
    logic [11:0] cur;
    logic [4:0]  dec;
    bit oh;
    cur = {s, g};
    oh = ($countones(s) == 1);
    if (oh && m_prev_valid && cur == m_prev) m_run++;
    else if (oh) m_run = 1;
    else m_run = 0;
    m_prev = cur;
    m_prev_valid = 1;
    m_upd = '0;
    if (m_run == STABLE + 1) begin
      dec = ref_decode(g[6:0]);
      for (int d = 0; d < DIGITS; d++) begin
        if (s[d]) begin
          m_bcd[d] = dec[3:0]; m_dp[d] = g[7]; m_err[d] = dec[4];
        end
      end
      m_upd = s;
    end
  endtask

  function automatic logic [15:0] m_bcd_flat();
    logic [15:0] r;
    for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = m_bcd[d];
    return r;
  endfunction

  function automatic logic [3:0] m_bits(input int which);
    logic [3:0] r;
    for (int d = 0; d < DIGITS; d++)
      r[d] = (which == 0) ? m_dp[d] : m_err[d];
    return r;
  endfunction

  int upd_pulses = 0;

  // Called at a falling edge: drive, take one rising edge, check, return at next fall.
  task automatic step(input logic [DIGITS-1:0] s, input logic [7:0] g);
    sel = s; seg = g;
    @(posedge clock);
    model_edge(s, g);
    #1;
    check_val("bcd", 32'(bcd), 32'(m_bcd_flat()));
    check_val("dp",  32'(dp),  32'(m_bits(0)));
    check_val("err", 32'(err), 32'(m_bits(1)));
    check_val("upd", 32'(upd), 32'(m_upd));
    if (upd != '0) upd_pulses++;
    @(negedge clock);
  endtask

  task automatic hold(input logic [DIGITS-1:0] s, input logic [7:0] g, input int n);
    for (int i = 0; i < n; i++) step(s, g);
  endtask

  // Asynchronous reset pulse in mid-cycle; bus inputs are left untouched.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check_val("rst_bcd", 32'(bcd), 32'h0000EEEE);
    check_val("rst_dp",  32'(dp),  32'h0);
    check_val("rst_err", 32'(err), 32'h0);
    check_val("rst_upd", 32'(upd), 32'h0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int p0;
    reset_n = 1'b1;
    sel = '0;
    seg = 8'h00;
    model_reset();
    @(negedge clock);
    do_reset();

    // Basic capture.
    upd_pulses = 0;
    hold(4'b0001, 8'h5B, 5);
    check_val("basic_upd", 32'(upd), 32'h1);
    check_val("basic_bcd0", 32'(bcd[3:0]), 32'h2);
    hold(4'b0001, 8'h5B, 5);
    check_val("basic_once", 32'(upd_pulses), 32'd1);

    // Too short a run.
    upd_pulses = 0;
    hold(4'b0010, 8'h06, 4);
    hold(4'b0000, 8'h00, 1);
    check_val("short_noupd", 32'(upd_pulses), 32'd0);
    check_val("short_bcd1", 32'(bcd[7:4]), 32'hE);

    // Illegal pattern with decimal point, then a legal one.
    hold(4'b0100, 8'hC9, 6);
    check_val("ill_bcd", 32'(bcd[11:8]), 32'hF);
    check_val("ill_err", 32'(err[2]), 32'h1);
    check_val("ill_dp",  32'(dp[2]),  32'h1);
    hold(4'b0100, 8'h07, 6);
    check_val("leg_bcd", 32'(bcd[11:8]), 32'h7);
    check_val("leg_err", 32'(err[2]), 32'h0);
    check_val("leg_dp",  32'(dp[2]),  32'h0);

    // Scan sequence.
    upd_pulses = 0;
    for (int d = 0; d < DIGITS; d++) begin
      hold(4'(1 << d), patterns[d + 1], 6);
      hold(4'b0000, 8'h00, 1);
    end
    check_val("scan_bcd", 32'(bcd), 32'h4321);
    check_val("scan_pulses", 32'(upd_pulses), 32'd4);

    // Multi-hot never captures; reset aborts a pending run.
    upd_pulses = 0;
    hold(4'b0011, 8'h3F, 10);
    check_val("multi_noupd", 32'(upd_pulses), 32'd0);
    hold(4'b1000, 8'h7F, 3);
    do_reset();
    hold(4'b1000, 8'h7F, 4);
    check_val("rstab_noupd", 32'(upd_pulses), 32'd0);
    hold(4'b1000, 8'h7F, 1);
    check_val("rstab_upd", 32'(upd), 32'h8);
    check_val("rstab_bcd", 32'(bcd), 32'h8EEE);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [DIGITS-1:0] rs;
      logic [7:0] rg;
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 7) rs = 4'(1 << $urandom_range(0, DIGITS - 1));
      else if (kind == 7) rs = 4'b0000;
      else rs = 4'($urandom_range(0, 15));
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        p0 = $urandom_range(0, 9);
        rg = patterns[p0];
      end else if (kind == 6) rg = 8'h00;
      else rg = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rg[7] = ~rg[7];
      hold(rs, rg, $urandom_range(1, 8));
      if ($urandom_range(0, 60) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
